// File: rtl/regfile_scb.sv
// Register file with a per-register pending scoreboard.
// Two combinational read ports, one write port, one reserve port.
module regfile_scb #(
    parameter int WIDTH   = 16,
    parameter int AW      = 3,
    parameter int BYPASS  = 1,
    parameter int ZERO_R0 = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 write,
    input  logic [AW-1:0]        writenum,
    input  logic [WIDTH-1:0]     data_in,
    input  logic [AW-1:0]        readnum_a,
    input  logic [AW-1:0]        readnum_b,
    output logic [WIDTH-1:0]     data_out_a,
    output logic [WIDTH-1:0]     data_out_b,
    output logic                 ready_a,
    output logic                 ready_b,
    input  logic                 reserve,
    input  logic [AW-1:0]        reservenum,
    output logic                 reserve_ack,
    output logic [(2**AW)-1:0]   busy,
    output logic [AW:0]          pend_count
);

    localparam int NREG = 2 ** AW;

    logic [WIDTH-1:0] regs [NREG];
    logic [NREG-1:0]  busy_q;
    logic [NREG-1:0]  busy_d;

    logic zero_w;
    logic zero_a;
    logic zero_b;
    logic zero_r;
    logic hit_a;
    logic hit_b;
    logic hit_r;
    logic byp_a;
    logic byp_b;
    logic store;

    // R0 is only special when the hard-wired zero option is on
    assign zero_w = (ZERO_R0 != 0) && (writenum == '0);
    assign zero_a = (ZERO_R0 != 0) && (readnum_a == '0);
    assign zero_b = (ZERO_R0 != 0) && (readnum_b == '0);
    assign zero_r = (ZERO_R0 != 0) && (reservenum == '0);

    assign hit_a = write && (writenum == readnum_a);
    assign hit_b = write && (writenum == readnum_b);
    assign hit_r = write && (writenum == reservenum);

    // Forwarding never applies to a hard-wired zero register
    assign byp_a = (BYPASS != 0) && hit_a && !zero_a;
    assign byp_b = (BYPASS != 0) && hit_b && !zero_b;

    assign store = write && !zero_w;

    // Read port A: zero reg, forwarded write data, or stored value
    always_comb begin
        data_out_a = regs[readnum_a];
        if (zero_a) begin
            data_out_a = '0;
        end else if (byp_a) begin
            data_out_a = data_in;
        end
    end

    // Read port B: same selection as port A
    always_comb begin
        data_out_b = regs[readnum_b];
        if (zero_b) begin
            data_out_b = '0;
        end else if (byp_b) begin
            data_out_b = data_in;
        end
    end

    // A read is ready when its value is committed or being forwarded
    always_comb begin
        ready_a = zero_a || !busy_q[readnum_a] || byp_a;
        ready_b = zero_b || !busy_q[readnum_b] || byp_b;
    end

    // A pending register can be re-reserved only as its result lands
    always_comb begin
        reserve_ack = reserve && (!busy_q[reservenum] || hit_r);
    end

    // Next pending vector: write retires, accepted reserve wins
    always_comb begin
        busy_d = busy_q;
        if (write) begin
            busy_d[writenum] = 1'b0;
        end
        if (reserve_ack && !zero_r) begin
            busy_d[reservenum] = 1'b1;
        end
        if (ZERO_R0 != 0) begin
            busy_d[0] = 1'b0;
        end
    end

    // Storage array, cleared asynchronously
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else if (store) begin
            regs[writenum] <= data_in;
        end
    end

    // Pending scoreboard register; outstanding reservations drop on reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign busy = busy_q;

    // Population count of the pending vector
    always_comb begin
        pend_count = '0;
        for (int i = 0; i < NREG; i++) begin
            pend_count = pend_count + {{AW{1'b0}}, busy_q[i]};
        end
    end

endmodule

// File: tb/tb_regfile_scb.sv
// Bench for regfile_scb: three parameter variants on shared stimulus,
// checked every cycle against a behavioural model plus literal pins.
module tb_regfile_scb;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        write = 1'b0;
    logic [2:0]  wn = '0;
    logic [15:0] din = '0;
    logic [2:0]  ra = '0;
    logic [2:0]  rb = '0;
    logic        reserve = 1'b0;
    logic [2:0]  rn = '0;

    logic [2:0][15:0] oa;
    logic [2:0][15:0] ob;
    logic [2:0]       rdy_a;
    logic [2:0]       rdy_b;
    logic [2:0]       ack;
    logic [2:0][7:0]  bsy;
    logic [2:0][3:0]  pc;

    int checks = 0;
    int passes = 0;

    // model state per variant: 0 default, 1 no bypass, 2 zero R0
    logic [15:0] mem [3][8];
    logic [7:0]  mbusy [3];

    always #5 clk = ~clk;

    regfile_scb #(.WIDTH(16), .AW(3), .BYPASS(1), .ZERO_R0(0)) u0 (
        .clk(clk), .rst_n(rst_n), .write(write), .writenum(wn),
        .data_in(din), .readnum_a(ra), .readnum_b(rb),
        .data_out_a(oa[0]), .data_out_b(ob[0]),
        .ready_a(rdy_a[0]), .ready_b(rdy_b[0]),
        .reserve(reserve), .reservenum(rn), .reserve_ack(ack[0]),
        .busy(bsy[0]), .pend_count(pc[0])
    );

    regfile_scb #(.WIDTH(16), .AW(3), .BYPASS(0), .ZERO_R0(0)) u1 (
        .clk(clk), .rst_n(rst_n), .write(write), .writenum(wn),
        .data_in(din), .readnum_a(ra), .readnum_b(rb),
        .data_out_a(oa[1]), .data_out_b(ob[1]),
        .ready_a(rdy_a[1]), .ready_b(rdy_b[1]),
        .reserve(reserve), .reservenum(rn), .reserve_ack(ack[1]),
        .busy(bsy[1]), .pend_count(pc[1])
    );

    regfile_scb #(.WIDTH(16), .AW(3), .BYPASS(1), .ZERO_R0(1)) u2 (
        .clk(clk), .rst_n(rst_n), .write(write), .writenum(wn),
        .data_in(din), .readnum_a(ra), .readnum_b(rb),
        .data_out_a(oa[2]), .data_out_b(ob[2]),
        .ready_a(rdy_a[2]), .ready_b(rdy_b[2]),
        .reserve(reserve), .reservenum(rn), .reserve_ack(ack[2]),
        .busy(bsy[2]), .pend_count(pc[2])
    );

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic bit has_byp(int k);
        return k != 1;
    endfunction

    function automatic bit has_z(int k);
        return k == 2;
    endfunction

    function automatic logic [15:0] exp_out(int k, logic [2:0] r);
        if (has_z(k) && r == 0) return 16'h0;
        if (has_byp(k) && write && wn == r) return din;
        return mem[k][r];
    endfunction

    function automatic logic exp_rdy(int k, logic [2:0] r);
        if (has_z(k) && r == 0) return 1'b1;
        if (has_byp(k) && write && wn == r) return 1'b1;
        return !mbusy[k][r];
    endfunction

    function automatic logic exp_ack(int k);
        return reserve && (!mbusy[k][rn] || (write && wn == rn));
    endfunction

    task automatic clear_model();
        for (int k = 0; k < 3; k++) begin
            mbusy[k] = 8'h00;
            for (int r = 0; r < 8; r++) mem[k][r] = 16'h0;
        end
    endtask

    task automatic model_edge();
        for (int k = 0; k < 3; k++) begin
            logic a;
            a = exp_ack(k);
            if (write && !(has_z(k) && wn == 0)) mem[k][wn] = din;
            if (write) mbusy[k][wn] = 1'b0;
            if (a && !(has_z(k) && rn == 0)) mbusy[k][rn] = 1'b1;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst_n) model_edge();
        #1;
    endtask

    // every-cycle comparison of all three variants against the model
    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            check($sformatf("u%0d out_a", k), oa[k], exp_out(k, ra));
            check($sformatf("u%0d out_b", k), ob[k], exp_out(k, rb));
            check($sformatf("u%0d rdy_a", k), rdy_a[k], exp_rdy(k, ra));
            check($sformatf("u%0d rdy_b", k), rdy_b[k], exp_rdy(k, rb));
            check($sformatf("u%0d ack", k), ack[k], exp_ack(k));
            check($sformatf("u%0d busy", k), bsy[k], mbusy[k]);
            check($sformatf("u%0d pend", k), pc[k],
                  $countones(mbusy[k]));
        end
    end

    initial begin
        clear_model();
        #2;
        check("rst busy", bsy[0], 8'h00);
        check("rst pend", pc[0], 4'd0);
        check("rst rdy_a", rdy_a[0], 1'b1);
        check("rst out_a", oa[0], 16'h0);
        tick();
        rst_n = 1'b1;

        // write then read back, then overwrite
        write = 1'b1; wn = 3'd3; din = 16'd12; ra = 3'd3;
        tick();
        write = 1'b0;
        #2;
        check("w3 out_a", oa[0], 16'd12);
        check("w3 rdy_a", rdy_a[0], 1'b1);
        write = 1'b1; din = 16'd30;
        tick();
        write = 1'b0;
        #2;
        check("w3b out_a", oa[0], 16'd30);

        // same-cycle forwarding versus no bypass
        write = 1'b1; wn = 3'd5; din = 16'd1100; rb = 3'd5;
        #2;
        check("byp out_b", ob[0], 16'd1100);
        check("nobyp out_b", ob[1], 16'd0);
        tick();
        write = 1'b0;
        #2;
        check("nobyp after", ob[1], 16'd1100);

        // reserve, duplicate reserve, retire
        reserve = 1'b1; rn = 3'd2; ra = 3'd2;
        #2;
        check("res2 ack", ack[0], 1'b1);
        tick();
        #2;
        check("res2 busy", bsy[0], 8'h04);
        check("res2 pend", pc[0], 4'd1);
        check("res2 rdy_a", rdy_a[0], 1'b0);
        check("res2 dup ack", ack[0], 1'b0);
        reserve = 1'b0; write = 1'b1; wn = 3'd2; din = 16'hFFFF;
        tick();
        write = 1'b0;
        #2;
        check("ret2 busy", bsy[0], 8'h00);
        check("ret2 rdy_a", rdy_a[0], 1'b1);
        check("ret2 out_a", oa[0], 16'hFFFF);

        // retire and re-reserve on the same edge
        reserve = 1'b1; rn = 3'd4;
        tick();
        write = 1'b1; wn = 3'd4; din = 16'd5689; ra = 3'd4;
        #2;
        check("rr4 ack", ack[0], 1'b1);
        tick();
        write = 1'b0; reserve = 1'b0;
        #2;
        check("rr4 out_a", oa[0], 16'd5689);
        check("rr4 busy", bsy[0], 8'h10);
        check("rr4 pend", pc[0], 4'd1);
        write = 1'b1;
        tick();
        write = 1'b0;

        // fill the scoreboard, then asynchronous reset mid-cycle
        for (int i = 0; i < 8; i++) begin
            reserve = 1'b1; rn = 3'(i);
            tick();
        end
        reserve = 1'b0; ra = 3'd3; rb = 3'd5;
        #2;
        check("full pend", pc[0], 4'd8);
        check("full busy", bsy[0], 8'hFF);
        check("full z busy", bsy[2], 8'hFE);
        check("full z pend", pc[2], 4'd7);
        #1;
        rst_n = 1'b0;
        clear_model();
        #1;
        check("arst busy", bsy[0], 8'h00);
        check("arst pend", pc[0], 4'd0);
        check("arst out_a", oa[0], 16'h0);
        check("arst out_b", ob[0], 16'h0);
        tick();
        rst_n = 1'b1;

        // hard-wired zero register
        write = 1'b1; wn = 3'd0; din = 16'd7;
        reserve = 1'b1; rn = 3'd0; ra = 3'd0;
        #2;
        check("z0 ack", ack[2], 1'b1);
        check("z0 out_a", oa[2], 16'h0);
        check("z0 rdy_a", rdy_a[2], 1'b1);
        tick();
        write = 1'b0; reserve = 1'b0;
        #2;
        check("z0 busy", bsy[2], 8'h00);
        check("z0 out after", oa[2], 16'h0);
        check("r0 plain out", oa[0], 16'd7);
        check("r0 plain busy", bsy[0], 8'h01);

        // randomized traffic with occasional asynchronous resets
        for (int n = 0; n < 400; n++) begin
            tick();
            rst_n = 1'b1;
            write = 1'($urandom_range(0, 1));
            wn = 3'($urandom_range(0, 7));
            din = 16'($urandom);
            ra = 3'($urandom_range(0, 7));
            rb = 3'($urandom_range(0, 7));
            reserve = 1'($urandom_range(0, 1));
            rn = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 63) == 0) begin
                #1;
                rst_n = 1'b0;
                clear_model();
            end
        end
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
